// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button debouncer.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_WAIT,
      ST_PRESSED,
      ST_RELEASE_WAIT
   } state_t;

   localparam int unsigned DEF_DEBOUNCE_CYCLES = 120000;
   localparam int unsigned DEF_LONG_CYCLES     = 12000000;
   localparam int unsigned COUNT_W             = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer with asynchronous reset to a selectable level.
module sync2 #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_meta <= RESET_VAL;
         r_q    <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounced push-button with press/release/long-press pulses and press counter.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               BTN_N,
   output logic               o_btn,
   output logic               o_press,
   output logic               o_release,
   output logic               o_long,
   output logic [COUNT_W-1:0] o_count,
   output logic               LEDG_N
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES - 1);

   state_t              r_state, w_state_nxt;
   logic [DW-1:0]       r_dcnt, w_dcnt_nxt;
   logic [HW-1:0]       r_hold, w_hold_nxt, w_hold_inc;
   logic                r_long_done, w_long_done_nxt;
   logic                r_btn, w_btn_nxt;
   logic                r_press, w_press_nxt;
   logic                r_release, w_release_nxt;
   logic                r_long, w_long_nxt;
   logic [COUNT_W-1:0]  r_count, w_count_nxt;
   logic                r_led_n;
   logic                w_btn_sync;
   logic                w_s;
   logic                w_long_hit;

   // Reset to 1 so the synchronized (active-low) button reads as not pressed.
   sync2 #(.RESET_VAL(1'b1)) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (BTN_N),
      .o_q     (w_btn_sync)
   );

   assign w_s = ~w_btn_sync;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= ST_RELEASED;
         r_dcnt      <= '0;
         r_hold      <= '0;
         r_long_done <= 1'b0;
         r_btn       <= 1'b0;
         r_press     <= 1'b0;
         r_release   <= 1'b0;
         r_long      <= 1'b0;
         r_count     <= '0;
         r_led_n     <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_dcnt      <= w_dcnt_nxt;
         r_hold      <= w_hold_nxt;
         r_long_done <= w_long_done_nxt;
         r_btn       <= w_btn_nxt;
         r_press     <= w_press_nxt;
         r_release   <= w_release_nxt;
         r_long      <= w_long_nxt;
         r_count     <= w_count_nxt;
         r_led_n     <= ~w_btn_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_dcnt_nxt      = r_dcnt;
      w_hold_nxt      = r_hold;
      w_long_done_nxt = r_long_done;
      w_btn_nxt       = r_btn;
      w_press_nxt     = 1'b0;
      w_release_nxt   = 1'b0;
      w_long_nxt      = 1'b0;
      w_count_nxt     = r_count;
      w_hold_inc      = (r_hold == H_MAX) ? r_hold : r_hold + HW'(1);
      w_long_hit      = (r_hold == H_MAX) && !r_long_done;

      case (r_state)
         ST_RELEASED: begin
            if (w_s) begin
               w_state_nxt = ST_PRESS_WAIT;
               w_dcnt_nxt  = '0;
            end
         end
         ST_PRESS_WAIT: begin
            if (!w_s) begin
               w_state_nxt = ST_RELEASED;
            end else if (r_dcnt == D_MAX) begin
               w_state_nxt     = ST_PRESSED;
               w_btn_nxt       = 1'b1;
               w_press_nxt     = 1'b1;
               w_count_nxt     = r_count + COUNT_W'(1);
               w_hold_nxt      = '0;
               w_long_done_nxt = 1'b0;
            end else begin
               w_dcnt_nxt = r_dcnt + DW'(1);
            end
         end
         ST_PRESSED: begin
            w_hold_nxt = w_hold_inc;
            if (w_long_hit) begin
               w_long_nxt      = 1'b1;
               w_long_done_nxt = 1'b1;
            end
            if (!w_s) begin
               w_state_nxt = ST_RELEASE_WAIT;
               w_dcnt_nxt  = '0;
            end
         end
         ST_RELEASE_WAIT: begin
            w_hold_nxt = w_hold_inc;
            if (w_s) begin
               w_state_nxt = ST_PRESSED;
            end else if (r_dcnt == D_MAX) begin
               w_state_nxt   = ST_RELEASED;
               w_btn_nxt     = 1'b0;
               w_release_nxt = 1'b1;
            end else begin
               w_dcnt_nxt = r_dcnt + DW'(1);
            end
            // Long pulse is held off on the release cycle so it never overlaps o_release.
            if (w_long_hit && !w_release_nxt) begin
               w_long_nxt      = 1'b1;
               w_long_done_nxt = 1'b1;
            end
         end
         default: w_state_nxt = ST_RELEASED;
      endcase
   end

   assign o_btn     = r_btn;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;
   assign o_count   = r_count;
   assign LEDG_N    = r_led_n;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_btn_debounce;

   logic       i_clk;
   logic       i_reset;
   logic       BTN_N;
   logic       o_btn;
   logic       o_press;
   logic       o_release;
   logic       o_long;
   logic [7:0] o_count;
   logic       LEDG_N;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_press, n_rel, n_long, n_overlap, n_btn0;
   int t_press, t_long, t_rel;

   btn_debounce #(
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (10)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .BTN_N     (BTN_N),
      .o_btn     (o_btn),
      .o_press   (o_press),
      .o_release (o_release),
      .o_long    (o_long),
      .o_count   (o_count),
      .LEDG_N    (LEDG_N)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic clear_stats();
      n_press = 0; n_rel = 0; n_long = 0; n_overlap = 0; n_btn0 = 0;
      t_press = -1; t_long = -1; t_rel = -1;
   endtask

   // Advance n rising edges, sampling 1 time unit after each edge.
   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge i_clk);
         #1;
         cyc++;
         if (o_press)   begin n_press++; t_press = cyc; end
         if (o_release) begin n_rel++;   t_rel   = cyc; end
         if (o_long)    begin n_long++;  t_long  = cyc; end
         if ((o_press && o_release) || (o_long && o_release)) n_overlap++;
         if (!o_btn) n_btn0++;
      end
   endtask

   task automatic test_reset();
      BTN_N = 1'b1;
      i_reset = 1'b1;
      #3;
      checks++;
      if (o_btn !== 1'b0 || LEDG_N !== 1'b1 || o_count !== 8'd0 || o_press !== 1'b0) begin
         errors++;
         $display("FAIL reset_vals: btn=%b led=%b cnt=%0d press=%b, want 0 1 0 0", o_btn, LEDG_N, o_count, o_press);
      end
      step(2);
      i_reset = 1'b0;
      clear_stats();
      step(50);
      checks++;
      if (n_press != 0 || n_rel != 0 || n_long != 0) begin
         errors++;
         $display("FAIL idle_pulses: press=%0d rel=%0d long=%0d, want 0 0 0", n_press, n_rel, n_long);
      end
      checks++;
      if (o_btn !== 1'b0 || LEDG_N !== 1'b1 || o_count !== 8'd0) begin
         errors++;
         $display("FAIL idle_vals: btn=%b led=%b cnt=%0d, want 0 1 0", o_btn, LEDG_N, o_count);
      end
   endtask

   task automatic test_glitch_and_press();
      int start;
      clear_stats();
      for (int g = 1; g <= 3; g++) begin
         BTN_N = 1'b0;
         step(g);
         BTN_N = 1'b1;
         step(6);
      end
      checks++;
      if (n_press != 0) begin
         errors++;
         $display("FAIL glitch_reject: presses=%0d, want 0", n_press);
      end
      BTN_N = 1'b0;
      start = cyc;
      step(7);
      checks++;
      if (t_press != start + 7 || n_press != 1) begin
         errors++;
         $display("FAIL press_latency: edge=%0d count=%0d, want edge 7 count 1", t_press - start, n_press);
      end
      checks++;
      if (o_count !== 8'd1 || o_btn !== 1'b1 || LEDG_N !== 1'b0) begin
         errors++;
         $display("FAIL press_vals: cnt=%0d btn=%b led=%b, want 1 1 0", o_count, o_btn, LEDG_N);
      end
   endtask

   task automatic test_long_and_release();
      int start;
      step(20);
      checks++;
      if (n_long != 1 || t_long != t_press + 10) begin
         errors++;
         $display("FAIL long_pulse: count=%0d offset=%0d, want 1 and 10", n_long, t_long - t_press);
      end
      BTN_N = 1'b1;
      start = cyc;
      step(7);
      checks++;
      if (n_rel != 1 || t_rel != start + 7) begin
         errors++;
         $display("FAIL release_latency: count=%0d edge=%0d, want 1 and 7", n_rel, t_rel - start);
      end
      checks++;
      if (o_btn !== 1'b0 || LEDG_N !== 1'b1 || n_overlap != 0) begin
         errors++;
         $display("FAIL release_vals: btn=%b led=%b overlap=%0d, want 0 1 0", o_btn, LEDG_N, n_overlap);
      end
      step(3);
   endtask

   task automatic test_bounce();
      int start;
      clear_stats();
      BTN_N = 1'b0;
      start = cyc;
      step(7);
      checks++;
      if (t_press != start + 7) begin
         errors++;
         $display("FAIL bounce_press: edge=%0d, want 7", t_press - start);
      end
      n_btn0 = 0;
      step(2);
      BTN_N = 1'b1; step(2);
      BTN_N = 1'b0; step(3);
      BTN_N = 1'b1; step(2);
      BTN_N = 1'b0; step(15);
      checks++;
      if (n_btn0 != 0 || n_rel != 0 || n_press != 1) begin
         errors++;
         $display("FAIL bounce_hold: btn_low=%0d rel=%0d press=%0d, want 0 0 1", n_btn0, n_rel, n_press);
      end
      checks++;
      if (n_long != 1 || t_long != t_press + 10) begin
         errors++;
         $display("FAIL bounce_long: count=%0d offset=%0d, want 1 and 10", n_long, t_long - t_press);
      end
      BTN_N = 1'b1;
      step(8);
      checks++;
      if (n_rel != 1 || o_count !== 8'd2) begin
         errors++;
         $display("FAIL bounce_release: rel=%0d cnt=%0d, want 1 and 2", n_rel, o_count);
      end
   endtask

   task automatic test_wrap();
      i_reset = 1'b1;
      step(2);
      i_reset = 1'b0;
      clear_stats();
      for (int i = 0; i < 256; i++) begin
         BTN_N = 1'b0; step(8);
         BTN_N = 1'b1; step(8);
         if (i == 254) begin
            checks++;
            if (o_count !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255: cnt=%0d, want 255", o_count);
            end
         end
         if (i == 255) begin
            checks++;
            if (o_count !== 8'd0) begin
               errors++;
               $display("FAIL wrap_0: cnt=%0d, want 0", o_count);
            end
         end
      end
      checks++;
      if (n_press != 256 || n_rel != 256 || n_overlap != 0) begin
         errors++;
         $display("FAIL wrap_pulses: press=%0d rel=%0d overlap=%0d, want 256 256 0", n_press, n_rel, n_overlap);
      end
   endtask

   task automatic test_reset_mid();
      int start;
      BTN_N = 1'b0;
      step(10);
      checks++;
      if (o_btn !== 1'b1) begin
         errors++;
         $display("FAIL mid_pressed_setup: btn=%b, want 1", o_btn);
      end
      i_reset = 1'b1;
      #1;
      checks++;
      if (o_btn !== 1'b0 || LEDG_N !== 1'b1 || o_count !== 8'd0 || o_press !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_pressed: btn=%b led=%b cnt=%0d press=%b, want 0 1 0 0", o_btn, LEDG_N, o_count, o_press);
      end
      step(2);
      i_reset = 1'b0;
      clear_stats();
      start = cyc;
      step(7);
      checks++;
      if (n_press != 1 || t_press != start + 7 || o_count !== 8'd1) begin
         errors++;
         $display("FAIL requalify_pressed: press=%0d edge=%0d cnt=%0d, want 1 7 1", n_press, t_press - start, o_count);
      end
      BTN_N = 1'b1;
      step(10);
      BTN_N = 1'b0;
      step(4);
      i_reset = 1'b1;
      #1;
      checks++;
      if (o_btn !== 1'b0 || LEDG_N !== 1'b1 || o_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid_wait: btn=%b led=%b cnt=%0d, want 0 1 0", o_btn, LEDG_N, o_count);
      end
      step(2);
      i_reset = 1'b0;
      clear_stats();
      start = cyc;
      step(7);
      checks++;
      if (n_press != 1 || t_press != start + 7) begin
         errors++;
         $display("FAIL requalify_wait: press=%0d edge=%0d, want 1 7", n_press, t_press - start);
      end
   endtask

   initial begin
      i_reset = 1'b1;
      BTN_N   = 1'b1;
      clear_stats();
      test_reset();
      test_glitch_and_press();
      test_long_and_release();
      test_bounce();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 120000, is the number of consecutive stable cycles required to accept a level change (10 ms at 12 MHz); legal range is 2 or more.
REQ-002 Parameter LONG_CYCLES, default 12000000, is the number of PRESSED cycles before a long-press pulse (1 s at 12 MHz); it SHALL be greater than DEBOUNCE_CYCLES.
REQ-003 i_clk  input  1  sole clock; one clock.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 BTN_N  input  1  raw push-button, active-low, asynchronous to i_clk, may bounce.
REQ-006 o_btn  output  1  debounced button level, active-high (1 = pressed).
REQ-007 o_press  output  1  one-cycle pulse on an accepted press.
REQ-008 o_release  output  1  one-cycle pulse on an accepted release.
REQ-009 o_long  output  1  one-cycle pulse once per press when the hold time reaches LONG_CYCLES.
REQ-010 o_count  output  8  count of accepted presses, wrapping.
REQ-011 LEDG_N  output  1  active-low LED; equals the inverse of o_btn.

Function
REQ-012 BTN_N SHALL pass through a two-flop synchronizer and then be inverted to an active-high signal s; no logic may use BTN_N before the second flop.
REQ-013 The FSM SHALL have four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 RELEASED: s=1 -> PRESS_WAIT with the debounce counter cleared; s=0 -> stay.
REQ-015 PRESS_WAIT: s=0 -> RELEASED (bounce rejected, no pulse); s=1 and counter==DEBOUNCE_CYCLES-1 -> PRESSED; otherwise the counter increments.
REQ-016 On the PRESS_WAIT->PRESSED transition: o_btn goes to 1 and o_press is 1 for exactly one cycle; o_count increments modulo 256 (255->0); the hold counter clears and the long-done flag clears.
REQ-017 PRESSED: the hold counter increments each cycle and saturates at LONG_CYCLES-1; on the cycle it first reaches LONG_CYCLES-1 with long-done clear, o_long pulses for one cycle and long-done sets; s=0 -> RELEASE_WAIT with the debounce counter cleared.
REQ-018 RELEASE_WAIT: s=1 -> PRESSED, with o_btn still 1, no pulse, and the hold counter and long-done retained; s=0 and counter==DEBOUNCE_CYCLES-1 -> RELEASED; otherwise the counter increments.
REQ-019 On RELEASE_WAIT->RELEASED: o_btn goes to 0 and o_release is 1 for exactly one cycle.
REQ-020 The hold counter SHALL keep counting while in RELEASE_WAIT, so a release bounce neither restarts nor suppresses the long press.
REQ-021 Latency: with BTN_N held steadily low, o_press asserts DEBOUNCE_CYCLES+3 rising edges after the first edge that samples BTN_N low; release is symmetric.
REQ-022 o_btn, o_press, o_release, o_long, o_count and LEDG_N SHALL all be registered outputs.
REQ-023 o_press and o_release SHALL never be 1 in the same cycle; o_long SHALL never coincide with o_release.
REQ-024 Counter widths SHALL be ceil(log2(N)) for their parameter N; no counter may overflow.

Reset
REQ-025 i_reset SHALL asynchronously force: FSM=RELEASED; both synchronizer flops to the not-pressed value (s=0); all counters and long-done to 0; o_btn=0, o_press=0, o_release=0, o_long=0, o_count=0, LEDG_N=1.
REQ-026 A reset asserted mid-press SHALL abort the press with no pulse; after reset deasserts, a button still held SHALL be re-qualified from RELEASED as a new press.

Structure
REQ-027 Package btn_pkg SHALL hold the FSM state type and the default constants (120000, 12000000, counter width 8).
REQ-028 The synchronizer SHALL be the sub-module sync2, a two-flop synchronizer with asynchronous reset and a parameterized reset value; everything else stays in btn_debounce.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10)
REQ-029 Reset then idle with BTN_N=1 for 50 cycles -> o_btn=0, LEDG_N=1, no pulses, o_count=0.
REQ-030 BTN_N low glitches of 1, 2 and 3 cycles separated by high -> no o_press; then a steady low -> o_press at edge 7, o_count=1.
REQ-031 Hold low for 20 cycles after acceptance -> exactly one o_long, 10 cycles after o_press; release -> one o_release 7 edges after BTN_N goes high.
REQ-032 While pressed, 2-cycle high bounces -> o_btn stays 1, no o_release, no second o_press, o_long timing unchanged.
REQ-033 256 clean presses -> o_count wraps 255->0; o_press pulse count = 256.
REQ-034 Assert i_reset mid-PRESSED and mid-PRESS_WAIT with BTN_N held low -> outputs return to reset values immediately; after deassert, o_press occurs again 7 edges later.
